atm_account_server: RTL

Account-side responder for the ATM front-end. It accepts transaction requests (PIN check, withdraw, balance, deposit) over a valid/ready request channel and returns an accept/deny response over a valid/ready response channel. It holds the single account's balance, the session authentication flag and the PIN-failure lockout state. It sits behind the ATM user-interface FSM, which acts as the initiator.

---
 rtl/atm_pkg.sv | 31 +++
 rtl/atm_pin_guard.sv | 49 ++++
 rtl/atm_account_server.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM account server: operation codes, response codes,
// FSM state encoding and datapath widths.
package atm_pkg;

  localparam int unsigned BalW = 14;
  localparam int unsigned PinW = 16;
  localparam int unsigned FailCntW = 3;

  typedef enum logic [1:0] {
    OpPinCheck = 2'b00,
    OpWithdraw = 2'b01,
    OpBalance  = 2'b10,
    OpDeposit  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    RspOk       = 3'b000,
    RspBadPin   = 3'b001,
    RspNoAuth   = 3'b010,
    RspNoFunds  = 3'b011,
    RspLocked   = 3'b100,
    RspOverflow = 3'b101
  } rsp_code_e;

  typedef enum logic [2:0] {
    StIdle = 3'b000,
    StExec = 3'b001,
    StResp = 3'b010
  } state_e;

endpackage

// File: rtl/atm_pin_guard.sv
// PIN failure tracking: counts consecutive bad PINs, saturates at MAX_PIN_TRIES and
// raises a sticky lock that only reset clears.
// Ports: clk, rst_n (sync, active-low), check_en (one PIN evaluation this cycle),
//        pin_match (evaluated PIN was correct), locked (sticky), fail_cnt (current count).
module atm_pin_guard
  import atm_pkg::*;
#(
  parameter int unsigned MAX_PIN_TRIES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                check_en,
  input  logic                pin_match,
  output logic                locked,
  output logic [FailCntW-1:0] fail_cnt
);

  localparam logic [FailCntW-1:0] MaxCnt = FailCntW'(MAX_PIN_TRIES);

  logic [FailCntW-1:0] fail_cnt_q, fail_cnt_d;
  logic                locked_q, locked_d;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    locked_d   = locked_q;
    if (check_en) begin
      if (pin_match) begin
        fail_cnt_d = '0;
      end else begin
        if (fail_cnt_q != MaxCnt) fail_cnt_d = fail_cnt_q + 1'b1;
        if (fail_cnt_d == MaxCnt) locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked   = locked_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: rtl/atm_account_server.sv
// Account-side responder for the ATM front-end. Accepts PIN check / withdraw / balance /
// deposit requests on a valid/ready channel and returns a registered accept/deny response.
// Ports: clk, rst_n (sync, active-low), cancel (ends session), req_valid/req_ready/req_op/
//        req_pin/req_amount (request channel), rsp_valid/rsp_ready/rsp_ok/rsp_code/
//        rsp_balance (response channel), locked (sticky lockout), state_display (FSM code).
module atm_account_server
  import atm_pkg::*;
#(
  parameter logic [PinW-1:0] ACCOUNT_PIN   = 16'h5612,
  parameter logic [BalW-1:0] INIT_BALANCE  = 14'd4000,
  parameter int unsigned     MAX_PIN_TRIES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cancel,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [PinW-1:0] req_pin,
  input  logic [BalW-1:0] req_amount,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_ok,
  output logic [2:0]      rsp_code,
  output logic [BalW-1:0] rsp_balance,
  output logic            locked,
  output logic [2:0]      state_display
);

  state_e          state_q, state_d;
  op_e             op_q;
  logic [PinW-1:0] pin_q;
  logic [BalW-1:0] amount_q;
  logic [BalW-1:0] balance_q, balance_d;
  logic            auth_q, auth_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_ok_q, rsp_ok_d;
  rsp_code_e       rsp_code_q, rsp_code_d;
  logic [BalW-1:0] rsp_balance_q, rsp_balance_d;

  logic                accept;
  logic                pin_match;
  logic                check_en;
  logic [FailCntW-1:0] fail_cnt;
  logic [BalW:0]       sum;

  assign req_ready = (state_q == StIdle) && rst_n;
  assign accept    = req_valid && req_ready;
  assign pin_match = (pin_q == ACCOUNT_PIN);
  // A locked account never evaluates the PIN, so the counter freezes at its limit.
  assign check_en  = (state_q == StExec) && (op_q == OpPinCheck) && !locked;
  assign sum       = {1'b0, balance_q} + {1'b0, amount_q};

  atm_pin_guard #(
    .MAX_PIN_TRIES(MAX_PIN_TRIES)
  ) u_pin_guard (
    .clk      (clk),
    .rst_n    (rst_n),
    .check_en (check_en),
    .pin_match(pin_match),
    .locked   (locked),
    .fail_cnt (fail_cnt)
  );

  always_comb begin
    state_d       = state_q;
    balance_d     = balance_q;
    auth_d        = auth_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_ok_d      = rsp_ok_q;
    rsp_code_d    = rsp_code_q;
    rsp_balance_d = rsp_balance_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_ok_d    = 1'b0;
        if (locked) begin
          rsp_code_d = RspLocked;
        end else if (op_q == OpPinCheck) begin
          auth_d = pin_match;
          if (pin_match) begin
            rsp_ok_d   = 1'b1;
            rsp_code_d = RspOk;
          end else begin
            rsp_code_d = RspBadPin;
          end
        end else if (!auth_q) begin
          rsp_code_d = RspNoAuth;
        end else begin
          rsp_ok_d   = 1'b1;
          rsp_code_d = RspOk;
          unique case (op_q)
            OpWithdraw: begin
              if (amount_q > balance_q) begin
                rsp_ok_d   = 1'b0;
                rsp_code_d = RspNoFunds;
              end else begin
                balance_d = balance_q - amount_q;
                auth_d    = 1'b0;  // one withdrawal per session
              end
            end
            OpDeposit: begin
              if (sum[BalW]) begin
                rsp_ok_d   = 1'b0;
                rsp_code_d = RspOverflow;
              end else begin
                balance_d = sum[BalW-1:0];
              end
            end
            default: ;  // balance query: no state change
          endcase
        end
        rsp_balance_d = balance_d;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b0;
      end
    endcase
    // Cancel overrides any auth update in the same cycle.
    if (cancel) auth_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      op_q          <= OpPinCheck;
      pin_q         <= '0;
      amount_q      <= '0;
      balance_q     <= INIT_BALANCE;
      auth_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_ok_q      <= 1'b0;
      rsp_code_q    <= RspOk;
      rsp_balance_q <= INIT_BALANCE;
    end else begin
      state_q       <= state_d;
      balance_q     <= balance_d;
      auth_q        <= auth_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_ok_q      <= rsp_ok_d;
      rsp_code_q    <= rsp_code_d;
      rsp_balance_q <= rsp_balance_d;
      if (accept) begin
        op_q     <= op_e'(req_op);
        pin_q    <= req_pin;
        amount_q <= req_amount;
      end
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_ok        = rsp_ok_q;
  assign rsp_code      = rsp_code_q;
  assign rsp_balance   = rsp_balance_q;
  assign state_display = state_q;

  // The lock is set exactly when the failure count reaches its limit, and stays in step.
  lock_tracks_count: assert property (@(posedge clk) disable iff (!rst_n)
    (fail_cnt <= FailCntW'(MAX_PIN_TRIES)) &&
    (locked == (fail_cnt == FailCntW'(MAX_PIN_TRIES))));

endmodule
